window_gen_3x3: RTL

Streaming 3×3 sliding-window generator that sits directly upstream of the per-channel convolution filter. It accepts one signed pixel per cycle in raster order and keeps two line buffers of the previous rows. For every pixel that completes a valid (unpadded) 3×3 neighbourhood, it presents all nine window taps in parallel, which drive the filter's x taps. There is no backpressure: the filter is fully pipelined and always accepts a window.

---
 rtl/window_gen_3x3.sv | 138 +++++++++++++
 1 files changed

// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module   : window_gen_3x3
// Brief    : Streaming 3x3 sliding-window generator with two line buffers.
//            Optional sof input is enabled by defining WINGEN_SOF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module window_gen_3x3 #(
    parameter int WIDTH = 10,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
`ifdef WINGEN_SOF_EN
    input  logic                       sof,
`endif
    output logic [9*WIDTH-1:0]         win,
    output logic                       win_valid,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       frame_done
);

    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = $clog2(IMG_H);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;
    logic               w_first;
    logic               w_emit;
    logic               w_last;

    // Taps are plain bit vectors: the window is a bit-exact pass-through of
    // the signed pixels, so no sign handling is needed here.
    logic [WIDTH-1:0] r_lb0 [IMG_W];
    logic [WIDTH-1:0] r_lb1 [IMG_W];
    logic [WIDTH-1:0] r_sh  [3][3];
    logic [WIDTH-1:0] w_sh  [3][3];
    logic [WIDTH-1:0] r_win [3][3];

    logic               r_win_valid;
    logic               r_frame_done;
    logic [c_ROW_W-1:0] r_win_row;
    logic [c_COL_W-1:0] r_win_col;

`ifdef WINGEN_SOF_EN
    assign w_first = in_valid && sof;
`else
    assign w_first = 1'b0;
`endif

    // Position of the pixel being accepted; sof restarts the frame at (0,0).
    always_comb begin
        w_col  = w_first ? '0 : r_col;
        w_row  = w_first ? '0 : r_row;
        w_emit = in_valid && (w_row >= c_ROW_TWO) && (w_col >= c_COL_TWO);
        w_last = in_valid && (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);
    end

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            w_sh[j][0] = r_sh[j][1];
            w_sh[j][1] = r_sh[j][2];
        end
        w_sh[0][2] = r_lb1[w_col];
        w_sh[1][2] = r_lb0[w_col];
        w_sh[2][2] = in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    // Line buffers and the shift window are never cleared: windows are only
    // emitted once two rows of the current frame have been written.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb1[w_col] <= r_lb0[w_col];
            r_lb0[w_col] <= in_data;
            r_sh         <= w_sh;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            for (int j = 0; j < 3; j++) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[j][i] <= '0;
                end
            end
        end else begin
            r_win_valid  <= w_emit;
            r_frame_done <= w_last;
            if (w_emit) begin
                r_win     <= w_sh;
                r_win_row <= w_row;
                r_win_col <= w_col;
            end
        end
    end

    for (genvar j = 0; j < 3; j++) begin : g_row
        for (genvar i = 0; i < 3; i++) begin : g_col
            assign win[(3*j+i)*WIDTH +: WIDTH] = r_win[j][i];
        end
    end

    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;

endmodule
`default_nettype wire
